// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the sysid checker master and its read engine.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        CHECK,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        TXN_IDLE,
        TXN_REQ,
        TXN_WAIT,
        TXN_GAP
    } txn_state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ID      = 2'd1;
    localparam logic [1:0] ERR_TS      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sysid_read_txn.sv
// Single Avalon-MM read: holds the request through waitrequest, times out
// waiting for readdatavalid and retries after a one-cycle gap.
module sysid_read_txn
    import sysid_checker_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_address,
    input  logic        i_waitrequest,
    input  logic        i_readdatavalid,
    input  logic [31:0] i_readdata,
    output logic        o_read,
    output logic        o_address,
    output logic        o_accept,
    output logic        o_retry,
    output logic        txn_done,
    output logic [31:0] txn_data,
    output logic        txn_timeout
);

    localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned RW = cnt_width(MAX_RETRIES);
    localparam logic [CW-1:0] CNT_SAT   = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    txn_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_retries;
    logic          r_addr;

    logic          w_active;
    logic          w_accept;
    logic          w_data_ok;
    logic          w_expire;
    logic          w_retry;
    logic          w_fail;
    logic          w_load;
    logic [CW-1:0] w_cnt_next;

    // Returned data and acceptance both beat an expiry landing in the same cycle.
    always_comb begin
        w_active   = (r_state == TXN_REQ) || (r_state == TXN_WAIT);
        w_accept   = (r_state == TXN_REQ) && !i_waitrequest;
        w_data_ok  = (r_state == TXN_WAIT) && i_readdatavalid;
        w_expire   = w_active && !w_accept && !w_data_ok && (r_cnt >= CNT_LAST);
        w_retry    = w_expire && (r_retries < RETRY_MAX);
        w_fail     = w_expire && !w_retry;
        w_load     = i_start && ((r_state == TXN_IDLE) || w_data_ok);
        w_cnt_next = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
    end

    // A new request may be loaded in the very cycle the previous word returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= TXN_IDLE;
            r_cnt     <= '0;
            r_retries <= '0;
            r_addr    <= 1'b0;
        end else if (w_load) begin
            r_state   <= TXN_REQ;
            r_cnt     <= '0;
            r_retries <= '0;
            r_addr    <= i_address;
        end else begin
            case (r_state)
                TXN_REQ, TXN_WAIT: begin
                    if (w_accept) begin
                        r_state <= TXN_WAIT;
                        r_cnt   <= w_cnt_next;
                    end else if (w_data_ok) begin
                        r_state   <= TXN_IDLE;
                        r_retries <= '0;
                    end else if (w_retry) begin
                        r_state   <= TXN_GAP;
                        r_retries <= r_retries + 1'b1;
                    end else if (w_fail) begin
                        r_state <= TXN_IDLE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                TXN_GAP: begin
                    r_state <= TXN_REQ;
                    r_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_read      = (r_state == TXN_REQ);
    assign o_address   = r_addr;
    assign o_accept    = w_accept;
    assign o_retry     = w_retry;
    assign txn_done    = w_data_ok;
    assign txn_data    = i_readdata;
    assign txn_timeout = w_fail;

endmodule

// File: rtl/sysid_checker_master.sv
// Avalon-MM master that reads the sysid ID and timestamp words and checks them.
// Optional macro SYSID_CHECK_PERIODIC_EN adds a periodic re-check from DONE.
module sysid_checker_master
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1486256668,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3
`ifdef SYSID_CHECK_PERIODIC_EN
    ,
    parameter int unsigned RECHECK_PERIOD     = 1_000_000
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  error_code,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value
);

    state_t      r_state;
    logic        r_done;
    logic        r_pass;
    logic [1:0]  r_err;
    logic [31:0] r_id;
    logic [31:0] r_ts;

    logic        w_ext_start;
    logic        w_kick;
    logic        w_go;
    logic        w_txn_start;
    logic        w_txn_addr;
    logic        w_accept;
    logic        w_retry;
    logic        w_txn_done;
    logic [31:0] w_txn_data;
    logic        w_txn_timeout;

    always_comb begin
        w_ext_start = start && ((r_state == IDLE) || (r_state == DONE));
        w_go        = w_ext_start || w_kick;
        w_txn_start = w_go || ((r_state == ID_WAIT) && w_txn_done);
        w_txn_addr  = (r_state == ID_WAIT) ? ADDR_TS : ADDR_ID;
    end

`ifdef SYSID_CHECK_PERIODIC_EN
    localparam int unsigned PW = cnt_width(RECHECK_PERIOD);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(RECHECK_PERIOD - 1);

    logic [PW-1:0] r_period;

    always_ff @(posedge clock) begin
        if (reset || (r_state != DONE) || w_go) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + 1'b1;
        end
    end

    assign w_kick = (r_state == DONE) && (r_period == PERIOD_LAST);
`else
    assign w_kick = 1'b0;
`endif

    sysid_read_txn #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_txn (
        .clock           (clock),
        .reset           (reset),
        .i_start         (w_txn_start),
        .i_address       (w_txn_addr),
        .i_waitrequest   (avm_waitrequest),
        .i_readdatavalid (avm_readdatavalid),
        .i_readdata      (avm_readdata),
        .o_read          (avm_read),
        .o_address       (avm_address),
        .o_accept        (w_accept),
        .o_retry         (w_retry),
        .txn_done        (w_txn_done),
        .txn_data        (w_txn_data),
        .txn_timeout     (w_txn_timeout)
    );

    // Periodic re-runs keep the previous result visible until CHECK replaces it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= ERR_OK;
            r_id    <= '0;
            r_ts    <= '0;
        end else if (w_txn_timeout) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
            r_err   <= ERR_TIMEOUT;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_go) begin
                        r_state <= ID_REQ;
                        if (w_ext_start) begin
                            r_done <= 1'b0;
                            r_pass <= 1'b0;
                            r_err  <= ERR_OK;
                        end
                    end
                end
                ID_REQ: if (w_accept) r_state <= ID_WAIT;
                ID_WAIT: begin
                    if (w_txn_done) begin
                        r_id    <= w_txn_data;
                        r_state <= TS_REQ;
                    end else if (w_retry) begin
                        r_state <= ID_REQ;
                    end
                end
                TS_REQ: if (w_accept) r_state <= TS_WAIT;
                TS_WAIT: begin
                    if (w_txn_done) begin
                        r_ts    <= w_txn_data;
                        r_state <= CHECK;
                    end else if (w_retry) begin
                        r_state <= TS_REQ;
                    end
                end
                CHECK: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    if (r_id != EXPECTED_ID) begin
                        r_pass <= 1'b0;
                        r_err  <= ERR_ID;
                    end else if (r_ts != EXPECTED_TIMESTAMP) begin
                        r_pass <= 1'b0;
                        r_err  <= ERR_TS;
                    end else begin
                        r_pass <= 1'b1;
                        r_err  <= ERR_OK;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy            = (r_state != IDLE) && (r_state != DONE);
    assign done            = r_done;
    assign pass            = r_pass;
    assign error_code      = r_err;
    assign id_value        = r_id;
    assign timestamp_value = r_ts;

endmodule

// File: tb/tb_sysid_checker_master.sv
// Directed, table-driven bench for sysid_checker_master with a behavioural sysid slave.
module tb_sysid_checker_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest   = 1'b0;
    logic [31:0] avm_readdata      = 32'h0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, pass;
    logic [1:0]  error_code;
    logic [31:0] id_value, timestamp_value;

    logic        t_start = 1'b0;
    logic        t_address, t_read, t_busy, t_done, t_pass;
    logic [1:0]  t_error_code;
    logic [31:0] t_id_value, t_timestamp_value;

    always #5 clock = ~clock;

    sysid_checker_master #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (32'd1486256668),
        .TIMEOUT_CYCLES     (255),
        .MAX_RETRIES        (3)
`ifdef SYSID_CHECK_PERIODIC_EN
        ,
        .RECHECK_PERIOD     (50)
`endif
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .error_code        (error_code),
        .id_value          (id_value),
        .timestamp_value   (timestamp_value)
    );

    // Second instance against a slave that never returns data.
    sysid_checker_master #(
        .TIMEOUT_CYCLES (8),
        .MAX_RETRIES    (2)
    ) dut_to (
        .clock             (clock),
        .reset             (reset),
        .start             (t_start),
        .avm_address       (t_address),
        .avm_read          (t_read),
        .avm_waitrequest   (1'b0),
        .avm_readdata      (32'h0),
        .avm_readdatavalid (1'b0),
        .busy              (t_busy),
        .done              (t_done),
        .pass              (t_pass),
        .error_code        (t_error_code),
        .id_value          (t_id_value),
        .timestamp_value   (t_timestamp_value)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: optional waitrequest stall, readdatavalid one cycle after acceptance.
    logic [31:0] cfg_id       = 32'd0;
    logic [31:0] cfg_ts       = 32'd1486256668;
    int          cfg_stall    = 0;
    logic        cfg_ts_rdv   = 1'b1;
    logic        inject_rdv   = 1'b0;
    int          stall_cnt    = 0;
    logic        acc_pending  = 1'b0;
    logic        acc_addr     = 1'b0;
    logic        prev_wr      = 1'b0;
    logic        prev_addr    = 1'b0;
    int          stab_err     = 0;

    always @(negedge clock) begin
        if (acc_pending && (acc_addr == 1'b0 || cfg_ts_rdv)) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = acc_addr ? cfg_ts : cfg_id;
        end else if (inject_rdv) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'hBAD0_0001;
            inject_rdv        = 1'b0;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = 32'hA5A5_A5A5;
        end
        acc_pending = 1'b0;
        if (prev_wr && (avm_read !== 1'b1 || avm_address !== prev_addr)) stab_err++;
        if (avm_read === 1'b1) begin
            if (stall_cnt < cfg_stall) begin
                avm_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                avm_waitrequest = 1'b0;
                stall_cnt       = 0;
                acc_pending     = 1'b1;
                acc_addr        = avm_address;
            end
        end else begin
            avm_waitrequest = 1'b0;
            stall_cnt       = 0;
        end
        prev_wr   = avm_waitrequest;
        prev_addr = avm_address;
    end

    int   t_attempts  = 0;
    int   t_addr_err  = 0;
    logic t_prev_read = 1'b0;

    always @(negedge clock) begin
        if (t_read && !t_prev_read) t_attempts++;
        if (t_read && t_address !== 1'b0) t_addr_err++;
        t_prev_read = t_read;
    end

    // Pulses start and counts rising edges (including the one sampling start) until done.
    task automatic run_check(output int cycles);
        @(negedge clock);
        start  = 1'b1;
        cycles = 0;
        do begin
            @(posedge clock);
            #1;
            cycles++;
            if (cycles == 1) begin
                start = 1'b0;
                chk("busy_after_start", busy, 1);
                chk("done_cleared_on_start", done, 0);
            end
        end while (!done && cycles < 400);
    endtask

    typedef struct {
        string       name;
        logic [31:0] id;
        logic [31:0] ts;
        int          stall;
        int          exp_cyc;
        logic        exp_pass;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc;
        int cnt;

        // Stall 9 keeps the request up for 10 cycles per word: 6 + 2*9 = 24.
        vecs[0] = '{"nominal",      32'd0,          32'd1486256668, 0, 6,  1'b1, 2'd0};
        vecs[1] = '{"id_mismatch",  32'h0000_0001,  32'd1486256668, 0, 6,  1'b0, 2'd1};
        vecs[2] = '{"waitrequest",  32'd0,          32'd1486256668, 9, 24, 1'b1, 2'd0};
        vecs[3] = '{"ts_mismatch",  32'd0,          32'h1234_5678,  0, 6,  1'b0, 2'd2};
        vecs[4] = '{"both_bad",     32'd5,          32'd7,          0, 6,  1'b0, 2'd1};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_read", avm_read, 0);
        chk("rst_address", avm_address, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", error_code, 0);
        chk("rst_id", id_value, 0);
        chk("rst_ts", timestamp_value, 0);
        @(negedge clock);
        reset = 1'b0;

        // Timeout path: 3 attempts, then error 3.
        t_start = 1'b1;
        @(posedge clock);
        #1;
        t_start = 1'b0;
        cnt = 0;
        while (!t_done && cnt < 300) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        chk("to_done", t_done, 1);
        chk("to_err", t_error_code, 3);
        chk("to_pass", t_pass, 0);
        chk("to_busy", t_busy, 0);
        chk("to_attempts", t_attempts, 3);
        chk("to_addr_stable", t_addr_err, 0);

        for (int i = 0; i < 5; i++) begin
            cfg_id    = vecs[i].id;
            cfg_ts    = vecs[i].ts;
            cfg_stall = vecs[i].stall;
            stab_err  = 0;
            run_check(cyc);
            chk({vecs[i].name, "_cycles"}, cyc, vecs[i].exp_cyc);
            chk({vecs[i].name, "_done"}, done, 1);
            chk({vecs[i].name, "_pass"}, pass, vecs[i].exp_pass);
            chk({vecs[i].name, "_err"}, error_code, vecs[i].exp_err);
            chk({vecs[i].name, "_id"}, id_value, vecs[i].id);
            chk({vecs[i].name, "_ts"}, timestamp_value, vecs[i].ts);
            chk({vecs[i].name, "_busy"}, busy, 0);
            chk({vecs[i].name, "_req_stable"}, stab_err, 0);
            repeat (3) @(posedge clock);
            #1;
            chk({vecs[i].name, "_done_held"}, done, 1);
        end
        cfg_stall = 0;

        // Reset while waiting for the timestamp word, then a stray readdatavalid.
        cfg_id     = 32'd0;
        cfg_ts     = 32'd1486256668;
        cfg_ts_rdv = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("tsw_busy", busy, 1);
        chk("tsw_address", avm_address, 1);
        chk("tsw_read", avm_read, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_read", avm_read, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_id", id_value, 0);
        @(negedge clock);
        reset      = 1'b0;
        inject_rdv = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("stray_busy", busy, 0);
        chk("stray_done", done, 0);
        chk("stray_ts", timestamp_value, 0);
        cfg_ts_rdv = 1'b1;
        run_check(cyc);
        chk("post_rst_cycles", cyc, 6);
        chk("post_rst_pass", pass, 1);
        chk("post_rst_err", error_code, 0);
        chk("post_rst_ts", timestamp_value, 32'd1486256668);

`ifdef SYSID_CHECK_PERIODIC_EN
        // Automatic re-run 50 cycles after done; slave timestamp now differs.
        cfg_ts = 32'h1111_1111;
        cnt = 0;
        do begin
            @(posedge clock);
            #1;
            cnt++;
        end while (!busy && cnt < 200);
        chk("per_start_delay", cnt, 50);
        chk("per_done_kept", done, 1);
        chk("per_pass_kept", pass, 1);
        cnt = 0;
        while (busy && cnt < 200) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        chk("per_done", done, 1);
        chk("per_pass", pass, 0);
        chk("per_err", error_code, 2);
        chk("per_ts", timestamp_value, 32'h1111_1111);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
